// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol sequencer.
//   state_t          : sequencer FSM states
//   SYM_DOT/SYM_DASH : symbol encoding stored in the letter code
//   MAX_SYMS_DEFAULT : default number of symbols per letter
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MARK       = 3'd1,
        SPACE_L    = 3'd2,
        LETTER_OUT = 3'd3,
        SPACE_W    = 3'd4,
        WORD_OUT   = 3'd5
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMS_DEFAULT = 5;

endpackage

// File: rtl/morse_sym_shreg.sv
// Symbol store for one letter: one enabled D flip-flop per symbol slot.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   en           : write sym_bit into slot idx
//   clr          : clear all slots (wins over en)
//   idx          : slot to write (symbol position within the letter)
//   sym_bit      : symbol value (0 = dot, 1 = dash)
//   code         : stored symbols, slot i at bit i
module morse_sym_shreg #(
    parameter int MAX_SYMS = 5,
    parameter int IW       = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clr,
    input  logic [IW-1:0]       idx,
    input  logic                sym_bit,
    output logic [MAX_SYMS-1:0] code
);

    for (genvar i = 0; i < MAX_SYMS; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!reset_n || clr) begin
                code[i] <= 1'b0;
            end else if (en && (idx == IW'(i))) begin
                code[i] <= sym_bit;
            end
        end
    end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Turns the conditioned Morse key into letters and word breaks.
// Marks and spaces are timed in timebase ticks; marks become dots or dashes,
// spaces close a letter (LETTER_GAP ticks) or emit a word break (WORD_GAP).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   tick         : 1-cycle timebase strobe
//   key          : conditioned key, 1 = pressed
//   out_valid    : letter or word break available
//   out_ready    : consumer ready; transfer when out_valid && out_ready
//   out_space    : 1 = word break, 0 = letter
//   out_code     : symbols, first at bit 0, 0 = dot, 1 = dash
//   out_len      : number of valid symbols
//   out_err      : letter had more than MAX_SYMS symbols
//   fsm_state    : current FSM state, for observation
// Output channel: out_valid is raised only together with fresh fields and
// is held, with all fields frozen, until the cycle where out_ready is high.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_SYMS   = MAX_SYMS_DEFAULT,
    parameter int DOT_MAX    = 2,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_space,
    output logic [MAX_SYMS-1:0] out_code,
    output logic [2:0]          out_len,
    output logic                out_err,
    output state_t              fsm_state
);

    localparam int CW = $clog2(WORD_GAP + 1);
    localparam int IW = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;

    localparam logic [CW-1:0] MARK_SAT = CW'(DOT_MAX + 1);
    localparam logic [CW-1:0] DOT_LIM  = CW'(DOT_MAX);
    localparam logic [CW-1:0] LGAP     = CW'(LETTER_GAP);
    localparam logic [CW-1:0] WGAP     = CW'(WORD_GAP);
    localparam logic [2:0]    LEN_MAX  = 3'(MAX_SYMS);

    state_t state, state_nx;

    logic [CW-1:0]       cnt, cnt_nx;
    logic [CW-1:0]       mark_inc, space_inc, space_nx;
    logic [2:0]          len;
    logic                err;
    logic [MAX_SYMS-1:0] code;
    logic                accept;
    logic                sym_bit;

    // Datapath controls from the output process
    logic sym_en, sym_clr, len_inc, err_set;
    logic load_letter, load_word, out_drop;

    // ------------------------------------------------------------------
    // Counter helpers. Both increments saturate; space_nx is the space
    // count after this cycle (a tick only counts while the key is up).
    // ------------------------------------------------------------------
    always_comb begin
        mark_inc  = (cnt >= MARK_SAT) ? cnt : cnt + 1'b1;
        space_inc = (cnt >= WGAP) ? cnt : cnt + 1'b1;
        space_nx  = (tick && !key) ? space_inc : cnt;
        accept    = out_valid && out_ready;
        sym_bit   = (cnt > DOT_LIM) ? SYM_DASH : SYM_DOT;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Key levels are used as edges: in each state the
    // key is known to have been at the opposite level.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (key) state_nx = MARK;
            end
            MARK: begin
                if (!key) begin
                    // A zero-tick mark is a glitch: nothing is added
                    if (cnt == '0 && len == 3'd0) state_nx = IDLE;
                    else                          state_nx = SPACE_L;
                end
            end
            SPACE_L: begin
                if (key)                    state_nx = MARK;
                else if (space_nx >= LGAP)  state_nx = LETTER_OUT;
            end
            LETTER_OUT: begin
                // Key is ignored here until the letter is taken
                if (accept) begin
                    if (key)                    state_nx = MARK;
                    else if (space_nx >= WGAP)  state_nx = WORD_OUT;
                    else                        state_nx = SPACE_W;
                end
            end
            SPACE_W: begin
                if (key)                    state_nx = MARK;
                else if (space_nx >= WGAP)  state_nx = WORD_OUT;
            end
            WORD_OUT: begin
                if (accept) state_nx = key ? MARK : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (datapath controls and next counter value)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_nx      = cnt;
        sym_en      = 1'b0;
        sym_clr     = 1'b0;
        len_inc     = 1'b0;
        err_set     = 1'b0;
        load_letter = 1'b0;
        load_word   = 1'b0;
        out_drop    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
            end
            MARK: begin
                if (!key) begin
                    // Key edge wins over a same-cycle tick
                    cnt_nx = '0;
                    if (cnt != '0) begin
                        if (len < LEN_MAX) begin
                            sym_en  = 1'b1;
                            len_inc = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end else if (tick) begin
                    cnt_nx = mark_inc;
                end
            end
            SPACE_L: begin
                if (key) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = space_nx;
                    if (space_nx >= LGAP) load_letter = 1'b1;
                end
            end
            LETTER_OUT: begin
                cnt_nx = space_nx;
                if (accept) begin
                    sym_clr = 1'b1;
                    if (key) begin
                        cnt_nx   = '0;
                        out_drop = 1'b1;
                    end else if (space_nx >= WGAP) begin
                        load_word = 1'b1;
                    end else begin
                        out_drop = 1'b1;
                    end
                end
            end
            SPACE_W: begin
                if (key) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = space_nx;
                    if (space_nx >= WGAP) load_word = 1'b1;
                end
            end
            WORD_OUT: begin
                if (accept) begin
                    cnt_nx   = '0;
                    out_drop = 1'b1;
                end
            end
            default: cnt_nx = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Tick counter, symbol count and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            len <= 3'd0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (sym_clr) begin
                len <= 3'd0;
                err <= 1'b0;
            end else begin
                if (len_inc) len <= len + 3'd1;
                if (err_set) err <= 1'b1;
            end
        end
    end

    morse_sym_shreg #(
        .MAX_SYMS (MAX_SYMS),
        .IW       (IW)
    ) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sym_en),
        .clr     (sym_clr),
        .idx     (IW'(len)),
        .sym_bit (sym_bit),
        .code    (code)
    );

    // ------------------------------------------------------------------
    // Output registers: loaded once per letter / word break, frozen until
    // accepted so the consumer never sees fields move under out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_space <= 1'b0;
            out_code  <= '0;
            out_len   <= 3'd0;
            out_err   <= 1'b0;
        end else if (load_letter) begin
            out_valid <= 1'b1;
            out_space <= 1'b0;
            out_code  <= code;
            out_len   <= len;
            out_err   <= err;
        end else if (load_word) begin
            out_valid <= 1'b1;
            out_space <= 1'b1;
            out_code  <= '0;
            out_len   <= 3'd0;
            out_err   <= 1'b0;
        end else if (out_drop) begin
            out_valid <= 1'b0;
            out_space <= 1'b0;
            out_code  <= '0;
            out_len   <= 3'd0;
            out_err   <= 1'b0;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer (DOT_MAX=2, LETTER_GAP=3,
// WORD_GAP=7, MAX_SYMS=5). Accepted transfers are collected at the
// falling edge; each scenario task checks them against hand values.
module tb_morse_symbol_sequencer;
    import morse_pkg::*;

    typedef struct packed {
        logic       space;
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } rec_t;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       key;
    logic       out_valid;
    logic       out_ready;
    logic       out_space;
    logic [4:0] out_code;
    logic [2:0] out_len;
    logic       out_err;
    state_t     fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    rec_t caps[$];

    morse_symbol_sequencer #(
        .MAX_SYMS   (5),
        .DOT_MAX    (2),
        .LETTER_GAP (3),
        .WORD_GAP   (7)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_space (out_space),
        .out_code  (out_code),
        .out_len   (out_len),
        .out_err   (out_err),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transfer monitor ----------------
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready)
            caps.push_back({out_space, out_code, out_len, out_err});
    end

    function automatic rec_t get_cap(input int i);
        if (i < caps.size()) return caps[i];
        return 'x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        key       = 1'b0;
        tick      = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        step();
        caps.delete();
    endtask

    // Key down for n ticks (first cycle enters MARK)
    task automatic press(input int n);
        key = 1'b1;
        step();
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Key up for n ticks (first cycle processes the release)
    task automatic gap(input int n);
        key = 1'b0;
        step();
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; key = 1'b1; tick = 1'b1; out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_space !== 1'b0) begin n_fail++; $display("FAIL reset_space: got %b want 0", out_space); end
        n_cmp++; if (out_code !== 5'b00000) begin n_fail++; $display("FAIL reset_code: got %b want 00000", out_code); end
        n_cmp++; if (out_len !== 3'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", out_len); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
        do_reset();
    endtask

    task automatic test_letter_e();
        rec_t r;
        do_reset();
        press(1);
        gap(3);
        step();
        step();
        r = get_cap(0);
        n_cmp++; if (caps.size() !== 1) begin n_fail++; $display("FAIL e_count: got %0d want 1", caps.size()); end
        n_cmp++; if (r.space !== 1'b0) begin n_fail++; $display("FAIL e_space: got %b want 0", r.space); end
        n_cmp++; if (r.code !== 5'b00000) begin n_fail++; $display("FAIL e_code: got %b want 00000", r.code); end
        n_cmp++; if (r.len !== 3'd1) begin n_fail++; $display("FAIL e_len: got %0d want 1", r.len); end
        n_cmp++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL e_err: got %b want 0", r.err); end
    endtask

    task automatic test_letter_a();
        rec_t r;
        do_reset();
        press(1);
        gap(1);
        press(3);
        gap(3);
        step();
        step();
        r = get_cap(0);
        n_cmp++; if (caps.size() !== 1) begin n_fail++; $display("FAIL a_count: got %0d want 1", caps.size()); end
        n_cmp++; if (r.code !== 5'b00010) begin n_fail++; $display("FAIL a_code: got %b want 00010", r.code); end
        n_cmp++; if (r.len !== 3'd2) begin n_fail++; $display("FAIL a_len: got %0d want 2", r.len); end
        n_cmp++; if (r.space !== 1'b0) begin n_fail++; $display("FAIL a_space: got %b want 0", r.space); end
    endtask

    task automatic test_word_break();
        rec_t r0, r1;
        do_reset();
        press(1);
        gap(7);
        for (int i = 0; i < 10; i++) do_tick();
        r0 = get_cap(0);
        r1 = get_cap(1);
        n_cmp++; if (caps.size() !== 2) begin n_fail++; $display("FAIL wb_count: got %0d want 2", caps.size()); end
        n_cmp++; if (r0.space !== 1'b0 || r0.len !== 3'd1) begin n_fail++; $display("FAIL wb_letter: got space=%b len=%0d want space=0 len=1", r0.space, r0.len); end
        n_cmp++; if (r1.space !== 1'b1) begin n_fail++; $display("FAIL wb_space: got %b want 1", r1.space); end
        n_cmp++; if (r1.len !== 3'd0 || r1.code !== 5'b00000 || r1.err !== 1'b0) begin n_fail++; $display("FAIL wb_fields: got len=%0d code=%b err=%b want 0/00000/0", r1.len, r1.code, r1.err); end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL wb_state: got %0d want IDLE", fsm_state); end
    endtask

    task automatic test_backpressure();
        rec_t r1;
        do_reset();
        out_ready = 1'b0;
        press(1);
        gap(3);
        // 20 cycles spanning 8 ticks with the consumer stalled
        for (int i = 0; i < 20; i++) begin
            tick = ((i % 2) == 0 && i < 16) ? 1'b1 : 1'b0;
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_space !== 1'b0 || out_code !== 5'b00000 ||
                out_len !== 3'd1 || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b s=%b c=%b l=%0d e=%b want 1/0/00000/1/0",
                         i, out_valid, out_space, out_code, out_len, out_err);
            end
        end
        tick = 1'b0;
        n_cmp++; if (caps.size() !== 0) begin n_fail++; $display("FAIL bp_no_xfer: got %0d want 0", caps.size()); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_space !== 1'b1 || out_len !== 3'd0) begin n_fail++; $display("FAIL bp_word_next: got v=%b s=%b l=%0d want 1/1/0", out_valid, out_space, out_len); end
        step();
        step();
        r1 = get_cap(1);
        n_cmp++; if (caps.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", caps.size()); end
        n_cmp++; if (r1.space !== 1'b1) begin n_fail++; $display("FAIL bp_space: got %b want 1", r1.space); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow_glitch();
        rec_t r;
        do_reset();
        // Five dots with a zero-tick glitch between the 2nd and 3rd
        for (int i = 0; i < 5; i++) begin
            press(1);
            gap(1);
            if (i == 1) begin
                key = 1'b1; step();
                key = 1'b0; step();
            end
        end
        // Sixth symbol is a dash and must be dropped
        press(3);
        gap(3);
        step();
        step();
        r = get_cap(0);
        n_cmp++; if (caps.size() !== 1) begin n_fail++; $display("FAIL ov_count: got %0d want 1", caps.size()); end
        n_cmp++; if (r.len !== 3'd5) begin n_fail++; $display("FAIL ov_len: got %0d want 5", r.len); end
        n_cmp++; if (r.code !== 5'b00000) begin n_fail++; $display("FAIL ov_code: got %b want 00000", r.code); end
        n_cmp++; if (r.err !== 1'b1) begin n_fail++; $display("FAIL ov_err: got %b want 1", r.err); end

        // Lone glitch with nothing pending: back to IDLE, nothing emitted
        do_reset();
        key = 1'b1; step();
        key = 1'b0; step();
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL gl_state: got %0d want IDLE", fsm_state); end
        for (int i = 0; i < 8; i++) do_tick();
        n_cmp++; if (caps.size() !== 0) begin n_fail++; $display("FAIL gl_count: got %0d want 0", caps.size()); end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        do_reset();
        key = 1'b1; step();
        do_tick();
        reset_n = 1'b0; key = 1'b0;
        step();
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL rm_mark_state: got %0d want IDLE", fsm_state); end
        reset_n = 1'b1;
        step();
        out_ready = 1'b0;
        press(1);
        gap(3);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 1", out_valid); end
        reset_n = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_len !== 3'd0 || out_code !== 5'b00000 || out_err !== 1'b0 || out_space !== 1'b0) begin
            n_fail++; $display("FAIL rm_outputs: got v=%b l=%0d c=%b e=%b s=%b want all 0", out_valid, out_len, out_code, out_err, out_space);
        end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL rm_state: got %0d want IDLE", fsm_state); end
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        caps.delete();
        press(3);
        gap(3);
        step();
        step();
        r = get_cap(0);
        n_cmp++; if (caps.size() !== 1) begin n_fail++; $display("FAIL t_count: got %0d want 1", caps.size()); end
        n_cmp++; if (r.code !== 5'b00001 || r.len !== 3'd1) begin n_fail++; $display("FAIL t_fields: got code=%b len=%0d want 00001/1", r.code, r.len); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n = 1'b0; key = 1'b0; tick = 1'b0; out_ready = 1'b1;
        test_reset();
        test_letter_e();
        test_letter_a();
        test_word_break();
        test_backpressure();
        test_overflow_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
